ssd_display_ctrl: RTL and testbench
===================================

Name: ssd_display_ctrl

Overview:
- Parametrised seven-segment display controller: the successor to hand-coded per-top SSD scanning, level-to-BCD split and hex decode.
- Accepts a binary value on a load pulse and shows it in decimal or hex across NUM_DIGITS multiplexed digits.
- Decimal conversion is a sequential double-dabble.
- Adds leading-zero blanking, a per-digit decimal point and an overflow indication.
- Sits in the top level between the game state machine (level/score) and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (legal 1..8).
- BIN_W, 14, width of the binary input value (legal 4..27).
- SCAN_DIV, 18, prescaler width: the digit index advances every 2^SCAN_DIV clocks (about 381 Hz per digit at 100 MHz).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- value  in  BIN_W  binary value to display.
- load  in  1  single-cycle pulse; capture value and mode_dec.
- mode_dec  in  1  1 = decimal display, 0 = hex display.
- blank_lz  in  1  1 = blank leading zeros.
- dp_mask  in  NUM_DIGITS  bit i set lights DP on digit i (live, not latched).
- busy  out  1  conversion in progress.
- overflow  out  1  last loaded value does not fit in NUM_DIGITS digits.
- an  out  NUM_DIGITS  one-hot active-low anodes.
- seg  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: busy=0, overflow=0, an=all ones, seg=8'hFF, prescaler=0, digit index=0, digit registers=0, mode register=decimal.
- load sampling:
  - load is honoured only when busy=0; a load while busy=1 is ignored entirely.
  - load and Reset in the same cycle: Reset wins.
- Hex mode, load at cycle T:
  - Digit i = value[4i+3:4i] (zero-extended), updated at T+1.
  - busy never asserts.
  - overflow = (value >> 4*NUM_DIGITS) != 0.
- Decimal mode, load at cycle T:
  - busy=1 from T+1 through T+BIN_W.
  - One shift-add-3 iteration per cycle.
  - Digit registers and overflow update atomically at T+BIN_W+1, and busy falls in that same cycle.
  - overflow = value >= 10^NUM_DIGITS (compared at load against a localparam).
  - The displayed digits are never partially updated during conversion; the previous value stays on the display.
- Overflow display: all digits show a dash (segment g only, seg=8'b11111101, DP still per dp_mask).
- Scan:
  - The prescaler counts 0..2^SCAN_DIV-1 and wraps.
  - On wrap, the digit index increments and wraps from NUM_DIGITS-1 back to 0.
- Registered outputs:
  - an and seg are registered; they change 1 cycle after the index changes.
  - an[idx]=0, all other anodes=1.
- Leading-zero blanking (blank_lz=1, no overflow): digit i is blanked (seg=8'hFF apart from DP) if all digits j>=i are 0 and i>0. Digit 0 is never blanked.
- Segment codes (Dp bit 1):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
  - A=00010001, b=11000001, C=01100011, d=10000101, E=01100001, F=01110001
- DP: seg[0] = ~dp_mask[idx], applied after blanking and dash substitution.
- Reset mid-conversion aborts; display returns to reset values.

Decomposition:
- Package ssd_pkg:
  - 8-bit segment constants SEG_0..SEG_F, SEG_DASH, SEG_BLANK.
  - A function hex_to_seg(4-bit) returning the 8-bit segment code.
- Sub-module ssd_bin2bcd_seq, parametrised by BIN_W and NUM_DIGITS:
  - Ports: start, bin, busy, done, bcd[4*NUM_DIGITS-1:0].
  - Shift register and iteration counter.
- ssd_display_ctrl owns: the load/mode latch, overflow compare, prescaler, index, blanking and output registers.

Test Plan:
- Reset, then release with no load; SCAN_DIV=2 for sim. Expect the anode sequence 1110,1101,1011,0111 repeating, one step every 4 clocks; digit 0 shows 8'b00000011, other digits show 8'b00000011 when blank_lz=0.
- Decimal load. Stimulus: load value=1234, mode_dec=1, BIN_W=14. Expect:
  - busy high for exactly 14 cycles.
  - Digits 4,3,2,1 on idx 0..3, seg 10011001, 00001101, 00100101, 10011111.
  - overflow=0.
- Hex load. Stimulus: load value=14'h2BEF, mode_dec=0. Expect:
  - busy stays 0.
  - Next-cycle digits F,E,b,2: seg 01110001, 01100001, 11000001, 00100101.
- Leading-zero blanking and DP. Stimulus: decimal load 7, blank_lz=1, dp_mask=4'b0010. Expect:
  - idx0 = 00011111.
  - idx1 = 11111110 (blank with DP lit).
  - idx2 and idx3 = 11111111.
- Overflow and ignored load. Stimulus: decimal load 10000. Expect:
  - overflow=1 and all digits 11111101.
  - A second load (value 5) during busy is ignored; overflow and dashes remain after busy falls.
- Reset mid-conversion. Stimulus: Reset asserted 5 cycles into a conversion of 9999. Expect:
  - busy=0, an=1111 and seg=8'hFF in the next cycle.
  - After Reset releases, digit 0 shows 0 and the other digits show 0 (blank_lz=0).

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared segment encodings and helpers for the seven-segment display controller.
// Segment bytes are {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
package ssd_pkg;

   localparam logic [7:0] SEG_0     = 8'b00000011;
   localparam logic [7:0] SEG_1     = 8'b10011111;
   localparam logic [7:0] SEG_2     = 8'b00100101;
   localparam logic [7:0] SEG_3     = 8'b00001101;
   localparam logic [7:0] SEG_4     = 8'b10011001;
   localparam logic [7:0] SEG_5     = 8'b01001001;
   localparam logic [7:0] SEG_6     = 8'b01000001;
   localparam logic [7:0] SEG_7     = 8'b00011111;
   localparam logic [7:0] SEG_8     = 8'b00000001;
   localparam logic [7:0] SEG_9     = 8'b00001001;
   localparam logic [7:0] SEG_A     = 8'b00010001;
   localparam logic [7:0] SEG_B     = 8'b11000001;
   localparam logic [7:0] SEG_C     = 8'b01100011;
   localparam logic [7:0] SEG_D     = 8'b10000101;
   localparam logic [7:0] SEG_E     = 8'b01100001;
   localparam logic [7:0] SEG_F     = 8'b01110001;
   localparam logic [7:0] SEG_DASH  = 8'b11111101;
   localparam logic [7:0] SEG_BLANK = 8'b11111111;

   function automatic logic [7:0] hex_to_seg(input logic [3:0] i_hex);
      logic [7:0] r;
      case (i_hex)
         4'h0:    r = SEG_0;
         4'h1:    r = SEG_1;
         4'h2:    r = SEG_2;
         4'h3:    r = SEG_3;
         4'h4:    r = SEG_4;
         4'h5:    r = SEG_5;
         4'h6:    r = SEG_6;
         4'h7:    r = SEG_7;
         4'h8:    r = SEG_8;
         4'h9:    r = SEG_9;
         4'hA:    r = SEG_A;
         4'hB:    r = SEG_B;
         4'hC:    r = SEG_C;
         4'hD:    r = SEG_D;
         4'hE:    r = SEG_E;
         default: r = SEG_F;
      endcase
      return r;
   endfunction

   // Decimal capacity limit of an n-digit display.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 step per clock, BIN_W steps per value.
// o_done strobes during the final step, with o_bcd carrying that step's result.
module ssd_bin2bcd_seq
   import ssd_pkg::*;
#(
   parameter int unsigned BIN_W      = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [BIN_W-1:0]        i_bin,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [4*NUM_DIGITS-1:0] o_bcd
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W);

   logic [SR_W-1:0]  r_sr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [SR_W-1:0]  w_adj;
   logic [SR_W-1:0]  w_shift;

   always_comb begin
      w_adj = r_sr;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (r_sr[BIN_W+4*d +: 4] >= 4'd5) w_adj[BIN_W+4*d +: 4] = r_sr[BIN_W+4*d +: 4] + 4'd3;
      end
      w_shift = {w_adj[SR_W-2:0], 1'b0};
   end

   assign o_bcd  = w_shift[SR_W-1 -: BCD_W];
   assign o_done = r_busy && (r_cnt == CNT_W'(BIN_W - 1));
   assign o_busy = r_busy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_sr   <= {{BCD_W{1'b0}}, i_bin};
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_sr  <= w_shift;
         r_cnt <= r_cnt + CNT_W'(1);
         if (o_done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ssd_display_ctrl.sv
// Multiplexed seven-segment controller: hex or decimal display of a loaded value,
// with leading-zero blanking, live decimal points and dash-on-overflow.
module ssd_display_ctrl
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_W      = 14,
   parameter int unsigned SCAN_DIV   = 18
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [BIN_W-1:0]      i_value,
   input  logic                  i_load,
   input  logic                  i_mode_dec,
   input  logic                  i_blank_lz,
   input  logic [NUM_DIGITS-1:0] i_dp_mask,
   output logic                  o_busy,
   output logic                  o_overflow,
   output logic [NUM_DIGITS-1:0] o_an,
   output logic [7:0]            o_seg
);

   localparam int unsigned DIG_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

   logic [SCAN_DIV-1:0]   r_presc;
   logic [IDX_W-1:0]      r_idx;
   logic [DIG_W-1:0]      r_digits;
   logic                  r_mode_dec;
   logic                  r_ovf_pend;
   logic                  r_overflow;
   logic [NUM_DIGITS-1:0] r_an;
   logic [7:0]            r_seg;

   logic                  w_busy;
   logic                  w_done;
   logic [DIG_W-1:0]      w_bcd;
   logic                  w_take;
   logic [63:0]           w_val64;
   logic                  w_ovf_dec;
   logic                  w_ovf_hex;
   logic [NUM_DIGITS-1:0] w_blank;
   logic                  w_zero_run;
   logic [3:0]            w_cur;
   logic [7:0]            w_seg_base;

   assign w_take    = i_load && !w_busy;
   assign w_val64   = 64'(i_value);
   assign w_ovf_dec = (w_val64 >= DEC_LIMIT);
   assign w_ovf_hex = ((w_val64 >> DIG_W) != 64'd0);

   ssd_bin2bcd_seq #(
      .BIN_W      (BIN_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_start (w_take && i_mode_dec),
      .i_bin   (i_value),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   // A digit blanks only when it and every more significant digit are zero.
   always_comb begin
      w_blank    = '0;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run && (r_digits[4*i +: 4] == 4'd0);
         if (i > 0) w_blank[i] = i_blank_lz && w_zero_run;
      end
   end

   always_comb begin
      w_cur = r_digits[4*r_idx +: 4];
      if (r_overflow)         w_seg_base = SEG_DASH;
      else if (w_blank[r_idx]) w_seg_base = SEG_BLANK;
      else                    w_seg_base = hex_to_seg(w_cur);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc    <= '0;
         r_idx      <= '0;
         r_digits   <= '0;
         r_mode_dec <= 1'b1;
         r_ovf_pend <= 1'b0;
         r_overflow <= 1'b0;
         r_an       <= '1;
         r_seg      <= SEG_BLANK;
      end else begin
         r_presc <= r_presc + SCAN_DIV'(1);
         if (r_presc == '1) begin
            r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
         end
         if (w_take) begin
            r_mode_dec <= i_mode_dec;
            if (i_mode_dec) begin
               r_ovf_pend <= w_ovf_dec;
            end else begin
               r_digits   <= w_val64[DIG_W-1:0];
               r_overflow <= w_ovf_hex;
            end
         end
         // Decimal result lands in one step so the display never shows a partial value.
         if (w_done && r_mode_dec) begin
            r_digits   <= w_bcd;
            r_overflow <= r_ovf_pend;
         end
         r_an  <= ~(NUM_DIGITS'(1) << r_idx);
         r_seg <= {w_seg_base[7:1], ~i_dp_mask[r_idx]};
      end
   end

   assign o_busy     = w_busy;
   assign o_overflow = r_overflow;
   assign o_an       = r_an;
   assign o_seg      = r_seg;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl with a fast scan prescaler.
module tb_ssd_display_ctrl;

   localparam int unsigned ND = 4;
   localparam int unsigned BW = 14;
   localparam int unsigned SD = 2;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic [BW-1:0] value    = '0;
   logic          load     = 1'b0;
   logic          mode_dec = 1'b1;
   logic          blank_lz = 1'b0;
   logic [ND-1:0] dp_mask  = '0;
   logic          busy;
   logic          overflow;
   logic [ND-1:0] an;
   logic [7:0]    seg;

   int n_tests = 0;
   int n_fail  = 0;

   ssd_display_ctrl #(
      .NUM_DIGITS (ND),
      .BIN_W      (BW),
      .SCAN_DIV   (SD)
   ) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_value    (value),
      .i_load     (load),
      .i_mode_dec (mode_dec),
      .i_blank_lz (blank_lz),
      .i_dp_mask  (dp_mask),
      .o_busy     (busy),
      .o_overflow (overflow),
      .o_an       (an),
      .o_seg      (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Returns at the negedge after the edge that sampled load.
   task automatic pulse_load(input logic [BW-1:0] v, input logic m);
      @(negedge clk);
      value    = v;
      mode_dec = m;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      for (int k = 0; k < 100; k++) begin
         if (!busy) break;
         cycles++;
         @(negedge clk);
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic read_digit(input int d, input logic [7:0] exp, input string tag);
      logic [ND-1:0] tgt;
      logic [7:0]    s;
      bit            found;
      tgt   = ~(ND'(1) << d);
      found = 1'b0;
      s     = 8'h00;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (an == tgt) begin
            found = 1'b1;
            s     = seg;
            break;
         end
      end
      check($sformatf("%s_an%0d_seen", tag, d), 32'(found), 32'd1);
      check($sformatf("%s_seg%0d", tag, d), 32'(s), 32'(exp));
   endtask

   task automatic read_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      read_digit(0, e0, tag);
      read_digit(1, e1, tag);
      read_digit(2, e2, tag);
      read_digit(3, e3, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            cyc;
      logic [ND-1:0] exp_an;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Scan sequence: one anode step every 2^SD clocks.
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_an = ~(ND'(1) << (((k - 1) / 4) % 4));
         check($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an));
         check($sformatf("scan_seg_%0d", k), 32'(seg), 32'h03);
      end

      // Decimal 1234.
      pulse_load(14'd1234, 1'b1);
      wait_idle(cyc);
      check("dec_busy_cycles", 32'(cyc), 32'd14);
      check("dec_ovf", 32'(overflow), 32'd0);
      read_all("dec1234", 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);

      // Hex 2BEF: no busy, digits next cycle.
      pulse_load(14'h2BEF, 1'b0);
      check("hex_busy", 32'(busy), 32'd0);
      check("hex_ovf", 32'(overflow), 32'd0);
      read_all("hex2bef", 8'b01110001, 8'b01100001, 8'b11000001, 8'b00100101);

      // Leading-zero blanking and DP on digit 1.
      blank_lz = 1'b1;
      dp_mask  = 4'b0010;
      pulse_load(14'd7, 1'b1);
      wait_idle(cyc);
      check("lz_busy_cycles", 32'(cyc), 32'd14);
      read_all("lz7", 8'b00011111, 8'b11111110, 8'b11111111, 8'b11111111);
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;

      // Overflow, with a second load during busy that must be ignored.
      pulse_load(14'd10000, 1'b1);
      repeat (3) @(negedge clk);
      check("ovf_busy_mid", 32'(busy), 32'd1);
      pulse_load(14'd5, 1'b1);
      wait_idle(cyc);
      check("ovf_flag", 32'(overflow), 32'd1);
      repeat (3) @(negedge clk);
      check("ovf_no_restart", 32'(busy), 32'd0);
      read_all("ovf", 8'b11111101, 8'b11111101, 8'b11111101, 8'b11111101);
      check("ovf_flag_hold", 32'(overflow), 32'd1);

      // Reset five cycles into a conversion of 9999.
      pulse_load(14'd9999, 1'b1);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_an", 32'(an), 32'hF);
      check("mrst_seg", 32'(seg), 32'hFF);
      check("mrst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      read_all("mrst", 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
      check("mrst_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
